mux4x1_sel_arbiter: RTL

//   Round-robin arbiter that drives the 2-bit select of the downstream 4:1 mux.

---
 rtl/mux4x1_sel_arbiter_if.sv | 13 +
 rtl/mux4x1_sel_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/mux4x1_sel_arbiter_if.sv
// Request/grant bundle between the four requesters and the mux select arbiter.
interface mux4x1_sel_arbiter_if #(
  parameter int unsigned DWELL_W = 4
);
  logic [3:0]         req;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         sel;
  logic [3:0]         grant;
  logic               sel_valid;

  modport master (output req, output dwell, input sel, input grant, input sel_valid);
  modport slave  (input req, input dwell, output sel, output grant, output sel_valid);
endinterface

// File: rtl/mux4x1_sel_arbiter.sv
// Round-robin arbiter driving the select of a downstream 4:1 mux, with a programmable dwell.
// Optional ARB_GAP_EN inserts a one-cycle idle gap between grants (break-before-make).
module mux4x1_sel_arbiter #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux4x1_sel_arbiter_if.slave  bus
);

`ifdef ARB_GAP_EN
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
`else
  typedef enum logic {IDLE, GRANT} state_t;
`endif

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         grant_q, grant_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         last_q, last_d;
  logic [DWELL_W-1:0] load;
  logic [2:0]         win;
`ifndef ARB_GAP_EN
  logic [2:0]         win_rr;
`endif

  // Returns {found, channel}; search order is ptr+1, ptr+2, ptr+3, ptr.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] ch;
    res = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      ch = ptr + 2'(i);
      if (!res[2] && r[ch]) res = {1'b1, ch};
    end
    return res;
  endfunction

  assign load = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win     = pick(bus.req, last_q);
`ifndef ARB_GAP_EN
    // Back-to-back re-arbitration uses the pointer as it will be after this grant ends.
    win_rr  = pick(bus.req, sel_q);
`endif
    case (state_q)
      IDLE: begin
        if (win[2]) begin
          state_d = GRANT;
          sel_d   = win[1:0];
          grant_d = 4'b0001 << win[1:0];
          cnt_d   = load;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] || cnt_q == DWELL_W'(1)) begin
          last_d = sel_q;
`ifdef ARB_GAP_EN
          state_d = GAP;
          grant_d = '0;
`else
          if (win_rr[2]) begin
            sel_d   = win_rr[1:0];
            grant_d = 4'b0001 << win_rr[1:0];
            cnt_d   = load;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
`endif
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
`ifdef ARB_GAP_EN
      GAP: begin
        if (win[2]) begin
          state_d = GRANT;
          sel_d   = win[1:0];
          grant_d = 4'b0001 << win[1:0];
          cnt_d   = load;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.sel_valid = |grant_q;

endmodule
